// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage load/store engine. It takes the EX/MEM register outputs,
// checks the access for legality and alignment, and runs one transaction on
// a variable-latency data bus that uses a req/ack handshake. Store data is
// steered onto the correct byte lanes. Load data is extracted from the
// returned word and then sign- or zero-extended. While a bus transaction is
// outstanding, StallM freezes the upstream pipeline.
//
// Parameters:
//   TIMEOUT    - maximum number of REQ cycles without mem_ack before a bus
//                error is raised; 0 disables the timeout
//
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   MemWriteM  - store request (wins over a load request)
//   ResultSrcM - 2'b01 marks a load
//   ALUoutM    - byte address of the access
//   funct3M    - access size and signedness
//   rs2M       - store data, right-justified
//   mem_req    - bus request, held until ack or timeout
//   mem_we     - bus write enable
//   mem_addr   - word-aligned bus address
//   mem_wdata  - lane-steered store data
//   mem_wstrb  - byte enables (zero for reads)
//   mem_ack    - bus completion, only looked at while mem_req is high
//   mem_rdata  - read word, valid together with mem_ack
//   ReadDataM  - registered, extended load result
//   StallM     - hold the IF/ID/EX/EX-MEM registers
//   FaultM     - one-cycle pulse for a misaligned or illegal access
//   BusErrM    - one-cycle pulse for a bus timeout
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUoutM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] rs2M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM,
  output logic        BusErrM
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdData_q, rdData_d;
  logic        fault_q, fault_d;
  logic        busErr_q, busErr_d;

  logic        isStore, isLoad, access;
  logic        legal, misaligned, accessOk;
  logic [31:0] stWdata;
  logic [3:0]  stWstrb;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [31:0] ldData;

  // Classify the instruction in the EX/MEM register. A store wins when both
  // the store and load flags are set. funct3[1:0] gives the size
  // (byte/half/word) and funct3[2] marks the unsigned load forms, which do
  // not exist for stores.
  always_comb begin
    isStore    = MemWriteM;
    isLoad     = !MemWriteM && (ResultSrcM == 2'b01);
    access     = isStore || isLoad;
    legal      = 1'b0;
    misaligned = 1'b0;
    if (isStore) begin
      legal = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
    end else if (isLoad) begin
      legal = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010) ||
              (funct3M == 3'b100) || (funct3M == 3'b101);
    end
    if (funct3M[1:0] == 2'b01) begin
      misaligned = ALUoutM[0];
    end else if (funct3M[1:0] == 2'b10) begin
      misaligned = (ALUoutM[1:0] != 2'b00);
    end
    accessOk = legal && !misaligned;
  end

  // Store lane steering. The data is replicated across every lane so that
  // the byte enables alone select which bytes the memory writes.
  always_comb begin
    stWdata = rs2M;
    stWstrb = 4'b1111;
    case (funct3M[1:0])
      2'b00: begin
        stWdata = {4{rs2M[7:0]}};
        stWstrb = 4'b0001 << ALUoutM[1:0];
      end
      2'b01: begin
        stWdata = {2{rs2M[15:0]}};
        stWstrb = 4'b0011 << {ALUoutM[1], 1'b0};
      end
      default: begin
        stWdata = rs2M;
        stWstrb = 4'b1111;
      end
    endcase
  end

  // Load extraction. The byte or half is taken from the lane that the low
  // address bits select, and then extended. This logic can read ALUoutM and
  // funct3M directly while the ack arrives, because the inputs are held
  // stable for the whole time StallM is high.
  always_comb begin
    case (ALUoutM[1:0])
      2'b00:   ldByte = mem_rdata[7:0];
      2'b01:   ldByte = mem_rdata[15:8];
      2'b10:   ldByte = mem_rdata[23:16];
      default: ldByte = mem_rdata[31:24];
    endcase
    ldHalf = ALUoutM[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3M)
      3'b000:  ldData = {{24{ldByte[7]}}, ldByte};
      3'b001:  ldData = {{16{ldHalf[15]}}, ldHalf};
      3'b100:  ldData = {24'd0, ldByte};
      3'b101:  ldData = {16'd0, ldHalf};
      default: ldData = mem_rdata;
    endcase
  end

  // Next-state and next-output logic. By default every register holds its
  // value and the two status pulses return to zero. DONE always goes back to
  // IDLE without looking at the inputs, so the instruction still present in
  // that cycle cannot start a second transaction. A timeout clears
  // ReadDataM so that a stale value cannot be mistaken for the missing
  // result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdData_d = rdData_q;
    fault_d  = 1'b0;
    busErr_d = 1'b0;
    StallM   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !accessOk) begin
          fault_d = 1'b1;
          state_d = DONE;
        end else if (access) begin
          StallM  = 1'b1;
          req_d   = 1'b1;
          we_d    = isStore;
          addr_d  = {ALUoutM[31:2], 2'b00};
          wdata_d = isStore ? stWdata : 32'd0;
          wstrb_d = isStore ? stWstrb : 4'b0000;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        StallM = 1'b1;
        if (mem_ack) begin
          req_d   = 1'b0;
          if (!we_q) begin
            rdData_d = ldData;
          end
          state_d = DONE;
        end else if ((TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1)) begin
          req_d    = 1'b0;
          busErr_d = 1'b1;
          rdData_d = 32'd0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Every bus-facing output comes from a flop.
  // An asynchronous reset therefore drops mem_req at once, even in the
  // middle of a transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'b0000;
      rdData_q <= 32'd0;
      fault_q  <= 1'b0;
      busErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdData_q <= rdData_d;
      fault_q  <= fault_d;
      busErr_q <= busErr_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign ReadDataM = rdData_q;
  assign FaultM    = fault_q;
  assign BusErrM   = busErr_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store engine that consumes the EX/MEM pipeline register outputs (ALUoutM, funct3M, rs2M, MemWriteM, ResultSrcM) and drives a variable-latency data-memory bus with a req/ack handshake. It performs byte-lane steering for stores and extension for loads, and detects misaligned or illegal accesses. StallM freezes the upstream pipeline while a bus transaction is outstanding. Sits between the EX/MEM register and the MEM/WB register.

Parameters:
TIMEOUT, 16, max cycles in REQ without mem_ack before bus error; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
MemWriteM  in  1  store request
ResultSrcM  in  2  2'b01 = load (result from memory)
ALUoutM  in  32  byte address
funct3M  in  3  access size/sign
rs2M  in  32  store data (unaligned, low bits)
mem_req  out  1  bus request, held until mem_ack or timeout
mem_we  out  1  1 = write
mem_addr  out  32  word address, ALUoutM with bits [1:0] = 0
mem_wdata  out  32  lane-steered store data
mem_wstrb  out  4  byte enables (0 on reads)
mem_ack  in  1  bus completion, sampled only while mem_req = 1
mem_rdata  in  32  read word, valid with mem_ack
ReadDataM  out  32  extended load result, registered
StallM  out  1  hold IF/ID/EX/EX-MEM registers
FaultM  out  1  misaligned/illegal access pulse
BusErrM  out  1  timeout pulse

Behaviour:
- Access = MemWriteM | (ResultSrcM == 2'b01). MemWriteM takes priority when both are set; the access is then a store.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
- Misaligned: half access with addr[0] = 1; word access with addr[1:0] != 0.
- States IDLE, REQ, DONE. All bus outputs and ReadDataM/FaultM/BusErrM are registered.
- Reset (async, any state): state IDLE, counter 0, every output 0. mem_req drops immediately even mid-transaction. Any late ack is ignored.
- IDLE, no access: stay, StallM = 0.
- IDLE, access illegal or misaligned: no bus cycle, FaultM = 1 for one cycle (next cycle), go DONE, StallM = 0 in the detect cycle.
- IDLE, access legal: StallM = 1 (combinational), register the bus outputs, go REQ.
- REQ: mem_req = 1, StallM = 1, counter increments each cycle.
  - If mem_ack: capture and extend mem_rdata (loads), clear mem_req, go DONE.
  - If no ack and TIMEOUT != 0 and counter == TIMEOUT-1: clear mem_req, BusErrM = 1 for one cycle, ReadDataM = 0, go DONE.
- DONE: StallM = 0 (pipeline advances this edge), clear the pulses, go IDLE. The same instruction is still present in DONE and must not restart.
- Latency: zero-wait memory gives 2 stall cycles. Ack on the Nth REQ cycle gives N+1 stall cycles.
- Store steering:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011 << (2*addr[1]).
  - SW: wdata = rs2, wstrb = 1111.
- Load extraction: select the byte/half at addr[1:0]/addr[1]. Sign-extend LB/LH; zero-extend LBU/LHU.
- ReadDataM holds its value until the next load completes. Stores and faults do not alter it.
- Inputs are guaranteed stable while StallM = 1. Ack outside REQ is ignored.

Test Plan:
- Reset asserted while in REQ with mem_req = 1 -> mem_req = 0 immediately, state IDLE. Ack one cycle later is ignored and ReadDataM stays 0.
- Store SB, ALUoutM = 0x103, rs2M = 0x000000AB, ack on first REQ cycle -> mem_addr = 0x100, wdata = 0xABABABAB, wstrb = 1000, mem_we = 1, StallM high exactly 2 cycles.
- Load LH at 0x202, mem_rdata = 0x8001_1234, ack after 3 REQ cycles -> ReadDataM = 0xFFFF8001, wstrb = 0000, 4 stall cycles. The same access with LHU -> ReadDataM = 0x00008001.
- Load LW at 0x0000_0006 -> no mem_req, FaultM pulses 1 cycle, StallM never 1, ReadDataM unchanged. Store funct3 = 011 -> the same fault response.
- TIMEOUT = 4, load LBU with no ack -> mem_req high 4 cycles then low, BusErrM pulses once, ReadDataM = 0, next access in IDLE proceeds normally.
- Back-to-back SW 0x10 then LW 0x10 with ack on first REQ -> the second transaction starts only after DONE/IDLE, and the two mem_req pulses are separated by at least 2 low cycles.
